// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout
//   Consumes registered VGA timing (hsync/vsync/en/pxl_x/pxl_y), fetches
//   palette-indexed pixels from a double-buffered downscaled frame buffer in
//   external sync-read RAM, maps them through a 12-bit palette and drives
//   4:4:4 RGB. Sync signals are delayed to match the fetch path, and the
//   display/draw buffers flip at the vsync assertion edge on request.
//
// Ports
//   pixel_clk, reset_n        : clock, asynchronous active-low reset
//   hsync_in/vsync_in/en_in   : timing from the sync generator
//   pxl_x/pxl_y               : active pixel coordinates
//   mem_rd/mem_addr/mem_data  : RAM read port, data valid MEM_LAT cycles
//                               after mem_rd; mem_addr MSB selects buffer
//   pal_we/pal_addr/pal_data  : palette write port {R,G,B}
//   swap_req/swap_ack         : buffer flip request / flip-taken pulse
//   display_buf/draw_buf      : scanned-out buffer and its complement
//   frame_start               : pulse on the vsync assertion edge
//   hsync_out/vsync_out/en_out: timing delayed by MEM_LAT+2 cycles
//   rgb                       : pixel colour, black while blanking
module vga_fb_scanout #(
  parameter int   H_PIXELS    = 640,
  parameter int   V_PIXELS    = 480,
  parameter logic H_POL       = 1'b0,
  parameter logic V_POL       = 1'b0,
  parameter int   SCALE_SHIFT = 1,
  parameter int   PIX_BITS    = 4,
  parameter int   MEM_LAT     = 2,
  parameter int   ADDR_W      = $clog2((H_PIXELS >> SCALE_SHIFT) *
                                       (V_PIXELS >> SCALE_SHIFT)) + 1
) (
  input  logic                        pixel_clk,
  input  logic                        reset_n,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        en_in,
  input  logic [$clog2(H_PIXELS)-1:0] pxl_x,
  input  logic [$clog2(V_PIXELS)-1:0] pxl_y,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [PIX_BITS-1:0]         mem_data,
  input  logic                        pal_we,
  input  logic [PIX_BITS-1:0]         pal_addr,
  input  logic [11:0]                 pal_data,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic                        display_buf,
  output logic                        draw_buf,
  output logic                        frame_start,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        en_out,
  output logic [11:0]                 rgb
);

  localparam int X_W   = $clog2(H_PIXELS);
  localparam int Y_W   = $clog2(V_PIXELS);
  localparam int FB_W  = H_PIXELS >> SCALE_SHIFT;
  localparam int LB_W  = ADDR_W - 1;
  localparam int DEPTH = MEM_LAT + 2;
  localparam int PAL_N = 2 ** PIX_BITS;
  // Low row bits that must be all ones for the line just finished to be the
  // last replica of a frame-buffer row; zero mask means every line steps.
  localparam logic [Y_W-1:0] Y_MASK = Y_W'((1 << SCALE_SHIFT) - 1);

  logic [LB_W-1:0]   line_base_q, line_base_d;
  logic [Y_W-1:0]    y_last_q, y_last_d;
  logic              en_prev_q, vs_prev_q;
  logic              pending_q, pending_d;
  logic              display_buf_q, display_buf_d;
  logic              swap_ack_q, swap_ack_d;
  logic              frame_start_q, frame_start_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DEPTH-1:0]  hs_pipe_q, hs_pipe_d;
  logic [DEPTH-1:0]  vs_pipe_q, vs_pipe_d;
  logic [DEPTH-1:0]  en_pipe_q, en_pipe_d;
  logic [11:0]       rgb_q, rgb_d;
  logic [11:0]       pal_q [PAL_N];
  logic [11:0]       pal_d [PAL_N];

  logic              vs_edge, en_fall, row_step, flip;
  logic [X_W-1:0]    x_s;

  always_comb begin
    vs_edge  = (vsync_in == V_POL) && (vs_prev_q != V_POL);
    en_fall  = !en_in && en_prev_q;
    // Row is taken from the last active cycle so pxl_y is never sampled
    // while en_in is low.
    row_step = ((y_last_q & Y_MASK) == Y_MASK);
    flip     = vs_edge && (pending_q || swap_req);
    x_s      = pxl_x >> SCALE_SHIFT;
  end

  always_comb begin
    y_last_d = en_in ? pxl_y : y_last_q;

    line_base_d = line_base_q;
    if (vs_edge)
      line_base_d = '0;
    else if (en_fall && row_step)
      line_base_d = line_base_q + LB_W'(FB_W);

    // A request arriving on the edge itself is honoured at that edge.
    pending_d     = flip ? 1'b0 : (pending_q || swap_req);
    display_buf_d = flip ? ~display_buf_q : display_buf_q;
    swap_ack_d    = flip;
    frame_start_d = vs_edge;

    mem_rd_d   = en_in;
    mem_addr_d = {display_buf_q, line_base_q + LB_W'(x_s)};

    hs_pipe_d = {hs_pipe_q[DEPTH-2:0], hsync_in};
    vs_pipe_d = {vs_pipe_q[DEPTH-2:0], vsync_in};
    en_pipe_d = {en_pipe_q[DEPTH-2:0], en_in};

    // Lookup reads the pre-write palette, so a same-cycle write is seen
    // only from the next cycle on.
    rgb_d = en_pipe_q[DEPTH-2] ? pal_q[mem_data] : '0;

    for (int unsigned i = 0; i < PAL_N; i++)
      pal_d[i] = pal_q[i];
    if (pal_we)
      pal_d[pal_addr] = pal_data;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      line_base_q   <= '0;
      y_last_q      <= '0;
      en_prev_q     <= 1'b0;
      vs_prev_q     <= ~V_POL;
      pending_q     <= 1'b0;
      display_buf_q <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      hs_pipe_q     <= {DEPTH{~H_POL}};
      vs_pipe_q     <= {DEPTH{~V_POL}};
      en_pipe_q     <= '0;
      rgb_q         <= '0;
      for (int unsigned i = 0; i < PAL_N; i++)
        pal_q[i] <= (i == 0) ? 12'h000 : 12'hFFF;
    end else begin
      line_base_q   <= line_base_d;
      y_last_q      <= y_last_d;
      en_prev_q     <= en_in;
      vs_prev_q     <= vsync_in;
      pending_q     <= pending_d;
      display_buf_q <= display_buf_d;
      swap_ack_q    <= swap_ack_d;
      frame_start_q <= frame_start_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      en_pipe_q     <= en_pipe_d;
      rgb_q         <= rgb_d;
      for (int unsigned i = 0; i < PAL_N; i++)
        pal_q[i] <= pal_d[i];
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign swap_ack    = swap_ack_q;
  assign display_buf = display_buf_q;
  assign draw_buf    = ~display_buf_q;
  assign frame_start = frame_start_q;
  assign hsync_out   = hs_pipe_q[DEPTH-1];
  assign vsync_out   = vs_pipe_q[DEPTH-1];
  assign en_out      = en_pipe_q[DEPTH-1];
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Testbench for vga_fb_scanout at default parameters (640x480, scale 2,
// 4-bit pixels, MEM_LAT=2). Timing is driven directly in compressed form;
// a two-stage RAM model supplies buffer 0 = (x_s+y_s)&15 and
// buffer 1 = (x_s+2*y_s+7)&15.
module tb_vga_fb_scanout;

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic        hsync_in  = 1'b1;
  logic        vsync_in  = 1'b1;
  logic        en_in     = 1'b0;
  logic [9:0]  pxl_x     = '0;
  logic [8:0]  pxl_y     = '0;
  logic        mem_rd;
  logic [17:0] mem_addr;
  logic [3:0]  mem_data;
  logic        pal_we    = 1'b0;
  logic [3:0]  pal_addr  = '0;
  logic [11:0] pal_data  = '0;
  logic        swap_req  = 1'b0;
  logic        swap_ack, display_buf, draw_buf, frame_start;
  logic        hsync_out, vsync_out, en_out;
  logic [11:0] rgb;

  logic        force_f = 1'b0;
  logic [3:0]  rd_p1 = '0, rd_p2 = '0;

  int pass_cnt = 0;
  int total    = 0;

  vga_fb_scanout #(.H_PIXELS(640), .V_PIXELS(480), .MEM_LAT(2)) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .en_in(en_in),
    .pxl_x(pxl_x), .pxl_y(pxl_y),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .display_buf(display_buf), .draw_buf(draw_buf),
    .frame_start(frame_start),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .en_out(en_out),
    .rgb(rgb)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [3:0] ram_f(input logic [17:0] a);
    int unsigned off, xs, ys;
    off = 32'(a[16:0]);
    xs  = off % 320;
    ys  = off / 320;
    if (a[17]) return 4'((xs + 2 * ys + 7) & 15);
    return 4'((xs + ys) & 15);
  endfunction

  always @(posedge pixel_clk) begin
    rd_p1 <= ram_f(mem_addr);
    rd_p2 <= rd_p1;
  end
  assign mem_data = force_f ? 4'hF : rd_p2;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic drive(input logic hs, input logic vs, input logic en,
                       input int x, input int y);
    hsync_in = hs;
    vsync_in = vs;
    en_in    = en;
    pxl_x    = 10'(x);
    pxl_y    = 9'(y);
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_rd"},      32'(mem_rd),      0);
    chk({tag, "_mem_addr"},    32'(mem_addr),    0);
    chk({tag, "_swap_ack"},    32'(swap_ack),    0);
    chk({tag, "_display_buf"}, 32'(display_buf), 0);
    chk({tag, "_draw_buf"},    32'(draw_buf),    1);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_hsync_out"},   32'(hsync_out),   1);
    chk({tag, "_vsync_out"},   32'(vsync_out),   1);
    chk({tag, "_en_out"},      32'(en_out),      0);
    chk({tag, "_rgb"},         32'(rgb),         0);
  endtask

  typedef struct {
    logic hs, vs, en;
    int   x, y;
    int   addr;
    logic [11:0] rgb;
    logic fs;
  } vec_t;

  function automatic vec_t mk(input logic hs, input logic vs, input logic en,
                              input int x, input int y, input int addr,
                              input logic [11:0] c, input logic fs);
    vec_t v;
    v.hs = hs; v.vs = vs; v.en = en; v.x = x; v.y = y;
    v.addr = addr; v.rgb = c; v.fs = fs;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [19];
    int acks;

    tbl[0]  = mk(1, 1, 0,   0, 0,   0, 12'h000, 0);
    tbl[1]  = mk(1, 1, 1,   0, 0,   0, 12'h000, 0);
    tbl[2]  = mk(1, 1, 1,   1, 0,   0, 12'h000, 0);
    tbl[3]  = mk(1, 1, 1,   2, 0,   1, 12'h111, 0);
    tbl[4]  = mk(1, 1, 1,   5, 0,   2, 12'h222, 0);
    tbl[5]  = mk(0, 1, 0,   0, 0,   0, 12'h000, 0);
    tbl[6]  = mk(1, 1, 0,   0, 1,   0, 12'h000, 0);
    tbl[7]  = mk(1, 1, 1,   0, 1,   0, 12'h000, 0);
    tbl[8]  = mk(1, 1, 1,   3, 1,   1, 12'h111, 0);
    tbl[9]  = mk(1, 1, 0,   0, 1,   0, 12'h000, 0);
    tbl[10] = mk(1, 1, 1,   2, 2, 321, 12'h222, 0);
    tbl[11] = mk(1, 1, 1, 639, 2, 639, 12'h000, 0);
    tbl[12] = mk(0, 1, 0,   0, 2,   0, 12'h000, 0);
    tbl[13] = mk(1, 0, 0,   0, 0,   0, 12'h000, 1);
    tbl[14] = mk(1, 0, 0,   0, 0,   0, 12'h000, 0);
    tbl[15] = mk(1, 1, 1,   4, 0,   2, 12'h222, 0);
    tbl[16] = mk(1, 1, 0,   0, 0,   0, 12'h000, 0);
    tbl[17] = mk(1, 1, 0,   0, 0,   0, 12'h000, 0);
    tbl[18] = mk(1, 1, 0,   0, 0,   0, 12'h000, 0);

    // Reset values
    @(posedge pixel_clk); @(posedge pixel_clk); #1;
    chk_reset_vals("rst");
    @(negedge pixel_clk); reset_n = 1'b1;
    #1;

    // Reset palette: index 3 is white
    drive(1, 1, 1, 6, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("rst_pal_idx3", 32'(rgb), 32'h0FFF);
    chk("rst_pal_en_out", 32'(en_out), 1);

    // Identity-grey palette
    for (int i = 0; i < 16; i++) begin
      pal_we   = 1'b1;
      pal_addr = 4'(i);
      pal_data = {4'(i), 4'(i), 4'(i)};
      @(posedge pixel_clk); #1;
    end
    pal_we = 1'b0;

    // Table: addresses, pixel colours, 4-cycle sync/enable alignment
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].hs, tbl[i].vs, tbl[i].en, tbl[i].x, tbl[i].y);
      chk($sformatf("tbl%0d_mem_rd", i), 32'(mem_rd), 32'(tbl[i].en));
      if (tbl[i].en)
        chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), tbl[i].addr);
      chk($sformatf("tbl%0d_frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
      if (i >= 3) begin
        chk($sformatf("tbl%0d_rgb", i),       32'(rgb),       32'(tbl[i-3].rgb));
        chk($sformatf("tbl%0d_hsync_out", i), 32'(hsync_out), 32'(tbl[i-3].hs));
        chk($sformatf("tbl%0d_vsync_out", i), 32'(vsync_out), 32'(tbl[i-3].vs));
        chk($sformatf("tbl%0d_en_out", i),    32'(en_out),    32'(tbl[i-3].en));
      end
    end

    // Blanking is black even with mem_data forced to F; active shows F
    force_f = 1'b1;
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("blank_forced_f_rgb", 32'(rgb), 0);
    drive(1, 1, 0, 0, 0);
    chk("active_forced_f_rgb", 32'(rgb), 32'h0FFF);
    drive(1, 1, 0, 0, 0);
    chk("blank_after_f_rgb", 32'(rgb), 0);
    force_f = 1'b0;

    // Line stepping through a whole frame
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    for (int y = 0; y < 480; y++) begin
      drive(1, 1, 1, 0, y);
      if (y == 1)   chk("line_row1",   32'(mem_addr), 0);
      if (y == 2)   chk("line_row2",   32'(mem_addr), 320);
      if (y == 479) chk("line_row479", 32'(mem_addr), 76480);
      drive(1, 1, 0, 0, y);
    end
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    chk("line_after_vs", 32'(mem_addr), 0);
    drive(1, 1, 0, 0, 0);

    // Swap: two requests mid-frame, one flip at the vsync edge
    acks = 0;
    drive(1, 1, 1, 20, 10);
    swap_req = 1'b1;
    drive(1, 1, 1, 22, 10);
    swap_req = 1'b0;
    acks += int'(swap_ack);
    chk("swap_pending_no_flip", 32'(display_buf), 0);
    for (int k = 0; k < 100; k++) begin
      drive(1, 1, (k % 4) != 0, 2 * k, 10);
      acks += int'(swap_ack);
    end
    swap_req = 1'b1;
    drive(1, 1, 0, 0, 10);
    swap_req = 1'b0;
    acks += int'(swap_ack);
    drive(1, 1, 0, 0, 10);
    acks += int'(swap_ack);
    drive(1, 0, 0, 0, 0);
    acks += int'(swap_ack);
    chk("swap_ack_at_vs",      32'(swap_ack),    1);
    chk("swap_fs_at_vs",       32'(frame_start), 1);
    chk("swap_display_buf",    32'(display_buf), 1);
    chk("swap_draw_buf",       32'(draw_buf),    0);
    for (int k = 0; k < 20; k++) begin
      drive(1, (k < 2) ? 1'b0 : 1'b1, 0, 0, 0);
      acks += int'(swap_ack);
    end
    chk("swap_ack_count", 32'(acks), 1);
    drive(1, 1, 1, 0, 0);
    chk("swap_first_addr", 32'(mem_addr), 32'h20000);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("swap_buf1_rgb", 32'(rgb), 32'h0777);

    // swap_req coincident with the vsync edge
    drive(1, 1, 0, 0, 0);
    swap_req = 1'b1;
    drive(1, 0, 0, 0, 0);
    swap_req = 1'b0;
    chk("coinc_swap_ack",    32'(swap_ack),    1);
    chk("coinc_display_buf", 32'(display_buf), 0);
    chk("coinc_draw_buf",    32'(draw_buf),    1);
    drive(1, 0, 0, 0, 0);
    chk("coinc_ack_one_cycle", 32'(swap_ack), 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("noreq_fs",          32'(frame_start), 1);
    chk("noreq_no_ack",      32'(swap_ack),    0);
    chk("noreq_display_buf", 32'(display_buf), 0);

    // Palette write coincident with lookup of the same index
    drive(1, 1, 1, 10, 0);
    drive(1, 1, 1, 10, 0);
    drive(1, 1, 0, 0, 0);
    pal_we   = 1'b1;
    pal_addr = 4'd5;
    pal_data = 12'hF00;
    drive(1, 1, 0, 0, 0);
    pal_we = 1'b0;
    chk("pal_old_colour", 32'(rgb), 32'h0555);
    drive(1, 1, 0, 0, 0);
    chk("pal_new_colour", 32'(rgb), 32'h0F00);

    // Reset pulse at row 100
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    for (int y = 0; y < 100; y++) begin
      drive(1, 1, 1, 0, y);
      drive(1, 1, 0, 0, y);
    end
    drive(1, 1, 1, 8, 100);
    chk("row100_addr", 32'(mem_addr), 16004);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge pixel_clk); #1;
    chk("midrst_held_mem_rd", 32'(mem_rd), 0);
    pxl_x = 10'd4;
    pxl_y = 9'd101;
    @(negedge pixel_clk); reset_n = 1'b1;
    @(posedge pixel_clk); #1;
    chk("postrst_line_base0", 32'(mem_addr), 2);
    drive(1, 1, 0, 0, 101);
    drive(1, 0, 0, 0, 0);
    chk("postrst_fs", 32'(frame_start), 1);
    drive(1, 1, 1, 0, 0);
    chk("postrst_addr0", 32'(mem_addr), 0);
    drive(1, 1, 1, 6, 0);
    chk("postrst_addr3", 32'(mem_addr), 3);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("postrst_rgb_idx0", 32'(rgb), 0);
    drive(1, 1, 0, 0, 0);
    chk("postrst_rgb_idx3", 32'(rgb), 32'h0FFF);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
